// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte-lane steering, misaligned accesses split into
// two word accesses, and load result alignment/extension one cycle after the last access.
module load_store_unit #(
  parameter int ADDR_WIDTH = 14,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  stall,
  output logic                  load_valid,
  output logic [XLEN-1:0]       load_data,
  output logic [ADDR_WIDTH-1:0] mem_adra,
  output logic [XLEN-1:0]       mem_dina,
  output logic [3:0]            mem_wea,
  input  logic [XLEN-1:0]       mem_douta
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SPLIT = 1'b1;

  logic [0:0]            state_reg, state_next;

  // Second-access context, captured when a split request is accepted
  logic [ADDR_WIDTH-1:0] spl_addr_reg;
  logic [XLEN-1:0]       spl_dhi_reg;
  logic [3:0]            spl_mhi_reg;
  logic                  spl_we_reg;
  logic [2:0]            spl_funct3_reg;
  logic [1:0]            spl_off_reg;

  // Load pipeline register used to form the result in the cycle after the last access
  logic                  load_pend_reg;
  logic [2:0]            funct3_reg;
  logic [1:0]            off_reg;
  logic                  split_reg;
  logic [XLEN-1:0]       low_buf_reg;

  logic [1:0]            off;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [3:0]            size_mask;
  logic [2*XLEN-1:0]     d64;
  logic [7:0]            m8;
  logic                  is_split;
  logic                  legal;
  logic                  accept;
  logic                  unused_addr_bits;

  assign off              = req_addr[1:0];
  assign word_addr        = req_addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  assign d64      = {{XLEN{1'b0}}, req_wdata} << {off, 3'b000};
  assign m8       = {4'b0000, size_mask} << off;
  assign is_split = |m8[7:4];

  always_comb begin
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~req_we;
      default:                legal = 1'b0;
    endcase
  end

  assign accept = req_valid && legal && (state_reg == ST_IDLE) && !reset;

  always_comb begin
    mem_adra   = word_addr;
    mem_dina   = d64[XLEN-1:0];
    mem_wea    = 4'b0000;
    stall      = 1'b0;
    state_next = ST_IDLE;
    if (reset) begin
      state_next = ST_IDLE;
    end else if (state_reg == ST_SPLIT) begin
      mem_adra = spl_addr_reg + 1'b1;
      mem_dina = spl_dhi_reg;
      mem_wea  = spl_we_reg ? spl_mhi_reg : 4'b0000;
    end else if (accept) begin
      mem_wea    = req_we ? m8[3:0] : 4'b0000;
      stall      = is_split;
      state_next = is_split ? ST_SPLIT : ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      spl_addr_reg   <= '0;
      spl_dhi_reg    <= '0;
      spl_mhi_reg    <= '0;
      spl_we_reg     <= 1'b0;
      spl_funct3_reg <= '0;
      spl_off_reg    <= '0;
      load_pend_reg  <= 1'b0;
      funct3_reg     <= '0;
      off_reg        <= '0;
      split_reg      <= 1'b0;
      low_buf_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      load_pend_reg <= 1'b0;
      if (state_reg == ST_SPLIT) begin
        if (!spl_we_reg) begin
          load_pend_reg <= 1'b1;
          funct3_reg    <= spl_funct3_reg;
          off_reg       <= spl_off_reg;
          split_reg     <= 1'b1;
          low_buf_reg   <= mem_douta;
        end
      end else if (accept) begin
        if (is_split) begin
          spl_addr_reg   <= word_addr;
          spl_dhi_reg    <= d64[2*XLEN-1:XLEN];
          spl_mhi_reg    <= m8[7:4];
          spl_we_reg     <= req_we;
          spl_funct3_reg <= req_funct3;
          spl_off_reg    <= off;
        end else if (!req_we) begin
          load_pend_reg <= 1'b1;
          funct3_reg    <= req_funct3;
          off_reg       <= off;
          split_reg     <= 1'b0;
        end
      end
    end
  end

  logic [XLEN-1:0]   word_lo;
  logic [XLEN-1:0]   word_hi;
  logic [2*XLEN-1:0] combined;
  logic [7:0]        comb_bytes [0:7];
  logic [XLEN-1:0]   r_word;
  logic [XLEN-1:0]   ext_word;

  assign word_lo  = split_reg ? low_buf_reg : mem_douta;
  assign word_hi  = split_reg ? mem_douta : '0;
  assign combined = {word_hi, word_lo};

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bytes
      assign comb_bytes[gi] = combined[8*gi +: 8];
    end
    // Byte lane gi of the result comes from byte (off + gi) of the two-word window
    for (gi = 0; gi < 4; gi++) begin : g_align
      assign r_word[8*gi +: 8] = comb_bytes[{1'b0, off_reg} + 3'(gi)];
    end
  endgenerate

  always_comb begin
    case (funct3_reg)
      3'b000:  ext_word = {{24{r_word[7]}}, r_word[7:0]};
      3'b001:  ext_word = {{16{r_word[15]}}, r_word[15:0]};
      3'b100:  ext_word = {24'b0, r_word[7:0]};
      3'b101:  ext_word = {16'b0, r_word[15:0]};
      default: ext_word = r_word;
    endcase
  end

  assign load_valid = load_pend_reg && !reset;
  assign load_data  = load_valid ? ext_word : '0;

endmodule
